alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter XLEN, default 32, datapath width in bits; legal values 8, 16, 32, 64.
REQ-002 Parameter SHAMT_W, default $clog2(XLEN), shift-amount width; not overridden by users.
REQ-003 The block SHALL use one clock (clk), and reset (rst) SHALL be asynchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 in_valid  input  1  operand/op presented.
REQ-007 in_ready  output  1  block can accept an operation.
REQ-008 op  input  5  operation code (REQ-014).
REQ-009 in1, in2  input  XLEN each  operands.
REQ-010 out_valid  output  1  result available.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 out  output  XLEN  result, registered.
REQ-013 err  output  1  result belongs to an illegal op; valid with out_valid.

Function
REQ-014 Op codes SHALL be: 0 ADD, 1 SLL, 2 SLT, 3 SLTU, 4 XOR, 5 SRL, 6 OR, 7 AND, 8 SUB, 9 EQ, 10 NE, 11 LT, 12 GE, 13 SRA, 14 LTU, 15 GEU, 16 MUL, 17 MULH, 18 MULHSU, 19 MULHU, 20 DIV, 21 DIVU, 22 REM, 23 REMU; 24-31 illegal.
REQ-015 Shifts SHALL use in2[SHAMT_W-1:0] as shift amount, covering the full range 0..XLEN-1.
REQ-016 Compare/branch ops (2,3,9-12,14,15) SHALL return zero-extended 1 or 0 in out.
REQ-017 MUL SHALL return low XLEN bits of the product; MULH/MULHSU/MULHU the high XLEN bits with signed*signed, signed*unsigned (in1 signed), unsigned*unsigned respectively.
REQ-018 DIV/REM SHALL truncate toward zero; remainder sign follows dividend.
REQ-019 Divide by zero SHALL give quotient all-ones and remainder = in1, err=0.
REQ-020 DIV of most-negative by -1 SHALL give most-negative; REM of same SHALL give 0, err=0.
REQ-021 Illegal op SHALL complete with base latency, out=0, err=1.
REQ-022 FSM states IDLE, CALC, DONE; in_ready SHALL be 1 only in IDLE.
REQ-023 Accept occurs on a clk edge with in_valid && in_ready; operands and op SHALL be captured at accept and later input changes ignored.
REQ-024 Ops 0-15 and illegal: IDLE -> DONE; out_valid SHALL rise on the edge after accept (latency 1).
REQ-025 Ops 16-23: IDLE -> CALC; iterative shift-add multiply or restoring divide, one bit per cycle, cycle counter 0..XLEN-1; CALC -> DONE after XLEN cycles, so out_valid rises XLEN+1 edges after accept.
REQ-026 DONE: out, err, out_valid SHALL hold stable until out_valid && out_ready on an edge, then go to IDLE with out_valid=0.
REQ-027 No accept in the same cycle as result handoff; back-to-back throughput is one op per (latency+1) cycles minimum.
REQ-028 Signed M-ops SHALL operate on magnitudes and correct the sign at CALC completion; no extra cycle.

Reset
REQ-029 rst high SHALL immediately force state IDLE, counter 0, out=0, err=0, out_valid=0; in_ready SHALL be 1 while rst is low in IDLE.
REQ-030 rst during CALC or DONE SHALL abort the operation without producing a result; the first accept after release SHALL behave as from power-up.

Verification (XLEN=32)
REQ-031 ADD in1=0xFFFFFFFF, in2=1, out_ready=1 -> out=0x00000000, err=0, out_valid one edge after accept.
REQ-032 SRA in1=0x80000000, in2=31 -> 0xFFFFFFFF; SLL in1=1, in2=0x3F -> 0x80000000 (only low 5 bits used).
REQ-033 MULH in1=in2=0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; out_valid exactly 33 edges after accept, in_ready=0 throughout.
REQ-034 DIV 7/0 -> 0xFFFFFFFF; REM 7/0 -> 7; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -7/2 -> 0xFFFFFFFF.
REQ-035 Backpressure: out_ready=0 for 5 cycles after out_valid -> out and out_valid stable, in_ready=0, new in_valid ignored; op=25 -> out=0, err=1.
REQ-036 rst pulse at CALC cycle 10 of DIVU -> out_valid=0 asynchronously, no result emitted; next ADD 2+3 -> out=5 with latency 1.

Source files
------------

// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle for alu_seq: the master drives the request and out_ready,
// the slave (the ALU) returns the registered result plus in_ready/out_valid/err.
interface alu_seq_if #(
  parameter int XLEN = 32
) ();
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      op;
  logic [XLEN-1:0] in1;
  logic [XLEN-1:0] in2;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out;
  logic            err;

  modport master (
    output in_valid, op, in1, in2, out_ready,
    input  in_ready, out_valid, out, err
  );

  modport slave (
    input  in_valid, op, in1, in2, out_ready,
    output in_ready, out_valid, out, err
  );
endinterface

// File: rtl/alu_seq.sv
// Sequential RV-style ALU: single-cycle ops finish in 1 edge, mul/div iterate one bit per cycle (XLEN+1 edges).
// Result holds in DONE until out_ready; no new operation is accepted until the result is handed off.
module alu_seq #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  logic     clk,
  input  logic     rst,
  alu_seq_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [SHAMT_W-1:0] r_cnt;
  logic [XLEN-1:0]    r_hi;
  logic [XLEN-1:0]    r_lo;
  logic [XLEN-1:0]    r_b;
  logic [XLEN-1:0]    r_a;
  logic [2:0]         r_mop;
  logic               r_neg;
  logic               r_dz;
  logic [XLEN-1:0]    r_out;
  logic               r_err;

  logic               w_in_ready;
  logic               w_out_valid;
  logic               w_accept;
  logic               w_is_m;
  logic               w_ill;
  logic               w_last;
  logic [SHAMT_W-1:0] w_shamt;
  logic [XLEN-1:0]    w_alu;

  logic               w_sa_en;
  logic               w_sb_en;
  logic               w_neg_a;
  logic               w_neg_b;
  logic [XLEN-1:0]    w_mag_a;
  logic [XLEN-1:0]    w_mag_b;

  logic [XLEN:0]      w_sum;
  logic [XLEN:0]      w_rsh;
  logic [XLEN:0]      w_diff;
  logic               w_qbit;
  logic [XLEN-1:0]    w_nhi;
  logic [XLEN-1:0]    w_nlo;
  logic [2*XLEN-1:0]  w_prod;
  logic [2*XLEN-1:0]  w_prod_s;
  logic [XLEN-1:0]    w_final;

  assign w_is_m   = bus.op[4] & ~bus.op[3];
  assign w_ill    = bus.op[4] & bus.op[3];
  assign w_shamt  = bus.in2[SHAMT_W-1:0];
  assign w_accept = bus.in_valid & w_in_ready;
  assign w_last   = (r_cnt == SHAMT_W'(XLEN - 1));

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) begin
          w_state_nxt = w_is_m ? CALC : DONE;
        end
      end
      CALC: begin
        if (w_last) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Single-cycle ops evaluated straight off the request so the accept edge registers the result
  always_comb begin
    w_alu = '0;
    case (bus.op)
      5'd0:    w_alu = bus.in1 + bus.in2;
      5'd1:    w_alu = bus.in1 << w_shamt;
      5'd2:    w_alu[0] = $signed(bus.in1) < $signed(bus.in2);
      5'd3:    w_alu[0] = bus.in1 < bus.in2;
      5'd4:    w_alu = bus.in1 ^ bus.in2;
      5'd5:    w_alu = bus.in1 >> w_shamt;
      5'd6:    w_alu = bus.in1 | bus.in2;
      5'd7:    w_alu = bus.in1 & bus.in2;
      5'd8:    w_alu = bus.in1 - bus.in2;
      5'd9:    w_alu[0] = bus.in1 == bus.in2;
      5'd10:   w_alu[0] = bus.in1 != bus.in2;
      5'd11:   w_alu[0] = $signed(bus.in1) < $signed(bus.in2);
      5'd12:   w_alu[0] = $signed(bus.in1) >= $signed(bus.in2);
      5'd13:   w_alu = $unsigned($signed(bus.in1) >>> w_shamt);
      5'd14:   w_alu[0] = bus.in1 < bus.in2;
      5'd15:   w_alu[0] = bus.in1 >= bus.in2;
      default: w_alu = '0;
    endcase
  end

  // Which M-op operands are signed: MULH(1), MULHSU(2, in1 only), DIV(4), REM(6)
  always_comb begin
    w_sa_en = 1'b0;
    w_sb_en = 1'b0;
    case (bus.op[2:0])
      3'd1:    begin w_sa_en = 1'b1; w_sb_en = 1'b1; end
      3'd2:    begin w_sa_en = 1'b1; w_sb_en = 1'b0; end
      3'd4:    begin w_sa_en = 1'b1; w_sb_en = 1'b1; end
      3'd6:    begin w_sa_en = 1'b1; w_sb_en = 1'b1; end
      default: begin w_sa_en = 1'b0; w_sb_en = 1'b0; end
    endcase
  end

  assign w_neg_a = w_sa_en & bus.in1[XLEN-1];
  assign w_neg_b = w_sb_en & bus.in2[XLEN-1];
  assign w_mag_a = w_neg_a ? (-bus.in1) : bus.in1;
  assign w_mag_b = w_neg_b ? (-bus.in2) : bus.in2;

  // Multiply step: {r_hi,r_lo} is the product register, r_lo's LSB selects the add
  assign w_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : {(XLEN+1){1'b0}});
  // Restoring divide step: shift the next dividend bit into the partial remainder
  assign w_rsh  = {r_hi, r_lo[XLEN-1]};
  assign w_diff = w_rsh - {1'b0, r_b};
  assign w_qbit = ~w_diff[XLEN];

  always_comb begin
    if (r_mop[2]) begin
      w_nhi = w_qbit ? w_diff[XLEN-1:0] : w_rsh[XLEN-1:0];
      w_nlo = {r_lo[XLEN-2:0], w_qbit};
    end else begin
      w_nhi = w_sum[XLEN:1];
      w_nlo = {w_sum[0], r_lo[XLEN-1:1]};
    end
  end

  assign w_prod   = {w_nhi, w_nlo};
  assign w_prod_s = r_neg ? (-w_prod) : w_prod;

  // Sign fix-up is folded into the last CALC cycle so completion costs no extra edge
  always_comb begin
    w_final = '0;
    if (!r_mop[2]) begin
      w_final = (r_mop[1:0] == 2'd0) ? w_prod_s[XLEN-1:0] : w_prod_s[2*XLEN-1:XLEN];
    end else if (r_dz) begin
      w_final = r_mop[1] ? r_a : {XLEN{1'b1}};
    end else if (r_mop[1]) begin
      w_final = r_neg ? (-w_nhi) : w_nhi;
    end else begin
      w_final = r_neg ? (-w_nlo) : w_nlo;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_hi  <= '0;
      r_lo  <= '0;
      r_b   <= '0;
      r_a   <= '0;
      r_mop <= '0;
      r_neg <= 1'b0;
      r_dz  <= 1'b0;
      r_out <= '0;
      r_err <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_cnt <= '0;
            if (w_is_m) begin
              r_mop <= bus.op[2:0];
              r_a   <= bus.in1;
              r_hi  <= '0;
              r_dz  <= (bus.in2 == '0);
              if (bus.op[2]) begin
                r_lo  <= w_mag_a;
                r_b   <= w_mag_b;
                r_neg <= bus.op[1] ? w_neg_a : (w_neg_a ^ w_neg_b);
              end else begin
                r_lo  <= w_mag_b;
                r_b   <= w_mag_a;
                r_neg <= w_neg_a ^ w_neg_b;
              end
            end else begin
              r_out <= w_ill ? '0 : w_alu;
              r_err <= w_ill;
            end
          end
        end
        CALC: begin
          r_hi  <= w_nhi;
          r_lo  <= w_nlo;
          r_cnt <= r_cnt + SHAMT_W'(1);
          if (w_last) begin
            r_cnt <= '0;
            r_out <= w_final;
            r_err <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out       = r_out;
  assign bus.err       = r_err;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (XLEN=32): hand-computed vectors, latencies, backpressure and mid-op reset.
module tb_alu_seq;
  logic clk;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  alu_seq_if #(.XLEN(32)) bus ();

  alu_seq #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one op with out_ready high; inputs are scrambled right after accept to prove capture.
  task automatic run_op(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r, output logic e, output int lat, output logic rdy_low);
    @(negedge clk);
    bus.op        = o;
    bus.in1       = a;
    bus.in2       = b;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in1      = ~a;
    bus.in2      = ~b;
    bus.op       = 5'd0;
    lat     = 1;
    rdy_low = 1'b1;
    while (!bus.out_valid && lat < 200) begin
      if (bus.in_ready) rdy_low = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
    r = bus.out;
    e = bus.err;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] r;
    logic        e;
    int          lat;
    logic        rl;
    logic        stable_ok;
    logic        seen_ov;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.op        = 5'd0;
    bus.in1       = '0;
    bus.in2       = '0;
    bus.out_ready = 1'b0;
    #2;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out", bus.out, 0);
    chk("rst_err", bus.err, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("idle_in_ready", bus.in_ready, 1);

    run_op(5'd0, 32'hFFFF_FFFF, 32'd1, r, e, lat, rl);
    chk("add_out", r, 32'h0);
    chk("add_err", e, 0);
    chk("add_lat", lat, 1);
    chk("handoff_out_valid", bus.out_valid, 0);
    chk("handoff_in_ready", bus.in_ready, 1);

    run_op(5'd13, 32'h8000_0000, 32'd31, r, e, lat, rl);
    chk("sra", r, 32'hFFFF_FFFF);
    run_op(5'd1, 32'd1, 32'h3F, r, e, lat, rl);
    chk("sll_mask", r, 32'h8000_0000);
    run_op(5'd5, 32'h8000_0000, 32'd4, r, e, lat, rl);
    chk("srl", r, 32'h0800_0000);
    run_op(5'd8, 32'd5, 32'd7, r, e, lat, rl);
    chk("sub", r, 32'hFFFF_FFFE);
    run_op(5'd2, 32'hFFFF_FFFF, 32'd1, r, e, lat, rl);
    chk("slt", r, 32'd1);
    run_op(5'd3, 32'hFFFF_FFFF, 32'd1, r, e, lat, rl);
    chk("sltu", r, 32'd0);
    run_op(5'd12, 32'hFFFF_FFFF, 32'd1, r, e, lat, rl);
    chk("ge", r, 32'd0);
    run_op(5'd9, 32'd3, 32'd3, r, e, lat, rl);
    chk("eq", r, 32'd1);
    run_op(5'd7, 32'hF0F0_1234, 32'h0FF0_FF00, r, e, lat, rl);
    chk("and", r, 32'h00F0_1200);

    run_op(5'd17, 32'h8000_0000, 32'h8000_0000, r, e, lat, rl);
    chk("mulh", r, 32'h4000_0000);
    chk("mulh_lat", lat, 33);
    chk("mulh_in_ready_low", rl, 1);
    run_op(5'd19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, e, lat, rl);
    chk("mulhu", r, 32'hFFFF_FFFE);
    chk("mulhu_lat", lat, 33);
    chk("mulhu_in_ready_low", rl, 1);
    run_op(5'd16, 32'd7, 32'hFFFF_FFFD, r, e, lat, rl);
    chk("mul", r, 32'hFFFF_FFEB);
    run_op(5'd18, 32'hFFFF_FFFF, 32'd2, r, e, lat, rl);
    chk("mulhsu", r, 32'hFFFF_FFFF);

    run_op(5'd20, 32'd7, 32'd0, r, e, lat, rl);
    chk("div_by0", r, 32'hFFFF_FFFF);
    chk("div_by0_err", e, 0);
    run_op(5'd22, 32'd7, 32'd0, r, e, lat, rl);
    chk("rem_by0", r, 32'd7);
    run_op(5'd20, 32'h8000_0000, 32'hFFFF_FFFF, r, e, lat, rl);
    chk("div_ovf", r, 32'h8000_0000);
    chk("div_ovf_err", e, 0);
    run_op(5'd22, 32'h8000_0000, 32'hFFFF_FFFF, r, e, lat, rl);
    chk("rem_ovf", r, 32'd0);
    run_op(5'd22, 32'hFFFF_FFF9, 32'd2, r, e, lat, rl);
    chk("rem_neg", r, 32'hFFFF_FFFF);
    run_op(5'd20, 32'hFFFF_FFF9, 32'd2, r, e, lat, rl);
    chk("div_neg", r, 32'hFFFF_FFFD);
    chk("div_lat", lat, 33);
    run_op(5'd21, 32'd100, 32'd7, r, e, lat, rl);
    chk("divu", r, 32'd14);
    run_op(5'd23, 32'd100, 32'd7, r, e, lat, rl);
    chk("remu", r, 32'd2);

    // Illegal op held under backpressure while another request is waved at the block
    @(negedge clk);
    bus.op        = 5'd25;
    bus.in1       = 32'd5;
    bus.in2       = 32'd6;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    bus.op  = 5'd0;
    bus.in1 = 32'd1;
    bus.in2 = 32'd1;
    chk("ill_lat", bus.out_valid, 1);
    stable_ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b1 || bus.out !== 32'd0 || bus.err !== 1'b1 || bus.in_ready !== 1'b0)
        stable_ok = 1'b0;
    end
    chk("bp_stable", stable_ok, 1);
    chk("ill_out", bus.out, 32'd0);
    chk("ill_err", bus.err, 1);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_valid", bus.out_valid, 0);
    chk("bp_release_ready", bus.in_ready, 1);

    // Reset in the middle of a DIVU
    @(negedge clk);
    bus.op       = 5'd21;
    bus.in1      = 32'd100;
    bus.in2      = 32'd7;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    chk("calc_in_ready", bus.in_ready, 0);
    rst = 1'b1;
    #1;
    chk("async_rst_in_ready", bus.in_ready, 1);
    chk("async_rst_valid", bus.out_valid, 0);
    chk("async_rst_out", bus.out, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen_ov = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen_ov = 1'b1;
    end
    chk("abort_no_result", seen_ov, 0);
    run_op(5'd0, 32'd2, 32'd3, r, e, lat, rl);
    chk("post_rst_add", r, 32'd5);
    chk("post_rst_lat", lat, 1);
    chk("post_rst_err", e, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
